// File: rtl/axil_master.sv
// ---------------------------------------------------------------------------
// axil_master
//   AXI-Lite initiator. Takes one command at a time from a simple
//   valid/ready command port, runs it as an AR/R read or an AW/W/B write,
//   and returns read data plus a one-bit error flag on a response port.
//
//   Handshake rule for every channel: a transfer happens on the rising edge
//   where valid && ready are both 1. The source holds valid and its payload
//   stable until that edge, and valid never depends on ready.
//
//   Optional feature (compile-time macro AXIL_MASTER_TIMEOUT_EN): a watchdog
//   aborts any AXI phase that makes no progress for TIMEOUT_CYC cycles and
//   reports it as an error response. Without the macro the block waits
//   indefinitely.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata  command in
//   rsp_valid/ready/rdata/err      response out
//   ar_*, r_*                      AXI-Lite read address / read data
//   aw_*, w_*, b_*                 AXI-Lite write address / data / response
//   o_dbg_state                    current FSM state (debug/observability)
//
// All outputs are registered; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module axil_master #(
  parameter int ADDR_WDTH   = 16,
  parameter int DATA_WDTH   = 32,
  parameter int RESP_WDTH   = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_WDTH-1:0] cmd_addr,
  input  logic [DATA_WDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_WDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp,
  output logic [2:0]           o_dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_A  = 3'd1;
  localparam logic [2:0] RD_D  = 3'd2;
  localparam logic [2:0] WR_AW = 3'd3;
  localparam logic [2:0] WR_B  = 3'd4;
  localparam logic [2:0] RSP   = 3'd5;

  logic [2:0] r_state;
  logic       r_aw_done;   // sticky: AW handshake already happened
  logic       r_w_done;    // sticky: W handshake already happened

  logic w_aw_done;
  logic w_w_done;
  logic w_leave;           // current AXI phase completes this cycle
  logic w_busy;
  logic w_timeout;

  assign w_aw_done = r_aw_done | (aw_valid & aw_ready);
  assign w_w_done  = r_w_done  | (w_valid  & w_ready);
  assign w_busy    = (r_state == RD_A) || (r_state == RD_D) ||
                     (r_state == WR_AW) || (r_state == WR_B);

  always_comb begin
    w_leave = 1'b0;
    case (r_state)
      RD_A:    w_leave = ar_ready;
      RD_D:    w_leave = r_valid;
      WR_AW:   w_leave = w_aw_done & w_w_done;
      WR_B:    w_leave = b_valid;
      default: w_leave = 1'b0;
    endcase
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
  logic [CNT_W-1:0] r_cnt;

  // Counter restarts whenever the state changes, so partial progress in
  // WR_AW (only one of AW/W done) does not extend the deadline.
  always_ff @(posedge clk) begin
    if (!rst_n || !w_busy || w_leave || w_timeout) r_cnt <= '0;
    else                                          r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = w_busy && !w_leave && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      ar_valid   <= 1'b0;
      ar_address <= '0;
      r_ready    <= 1'b0;
      aw_valid   <= 1'b0;
      aw_address <= '0;
      w_valid    <= 1'b0;
      w_data     <= '0;
      b_ready    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              aw_address <= cmd_addr;
              w_data     <= cmd_wdata;
              aw_valid   <= 1'b1;
              w_valid    <= 1'b1;
              r_state    <= WR_AW;
            end else begin
              ar_address <= cmd_addr;
              ar_valid   <= 1'b1;
              r_state    <= RD_A;
            end
          end
        end
        RD_A: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= RD_D;
          end
        end
        RD_D: begin
          if (r_valid) begin
            r_ready   <= 1'b0;
            rsp_rdata <= r_data;
            rsp_err   <= |r_resp;
            rsp_valid <= 1'b1;
            r_state   <= RSP;
          end
        end
        WR_AW: begin
          if (aw_valid && aw_ready) aw_valid <= 1'b0;
          if (w_valid && w_ready)   w_valid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            b_ready   <= 1'b1;
            r_state   <= WR_B;
          end else begin
            r_aw_done <= w_aw_done;
            r_w_done  <= w_w_done;
          end
        end
        WR_B: begin
          if (b_valid) begin
            b_ready   <= 1'b0;
            rsp_err   <= |b_resp;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            r_state   <= RSP;
          end
        end
        RSP: begin
          // cmd_ready rises only on the next cycle, so a new command can
          // never be taken in the same cycle the response is consumed.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_timeout) begin
        ar_valid  <= 1'b0;
        r_ready   <= 1'b0;
        aw_valid  <= 1'b0;
        w_valid   <= 1'b0;
        b_ready   <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= 1'b1;
        r_state   <= RSP;
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axil_master.sv
// ---------------------------------------------------------------------------
// tb_axil_master
//   Directed bench for axil_master. Inputs are driven and outputs sampled
//   1 ns after each rising edge; the responder is played by hand per test.
// ---------------------------------------------------------------------------
module tb_axil_master;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          ar_valid, ar_ready;
  logic [AW-1:0] ar_address;
  logic          r_valid, r_ready;
  logic [DW-1:0] r_data;
  logic [0:0]    r_resp;
  logic          aw_valid, aw_ready;
  logic [AW-1:0] aw_address;
  logic          w_valid, w_ready;
  logic [DW-1:0] w_data;
  logic          b_valid, b_ready;
  logic [0:0]    b_resp;
  logic [2:0]    o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  axil_master #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(1), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 0;
  endtask

  task automatic all_quiet(input string tag);
    check({tag, "_arv"}, ar_valid, 0);
    check({tag, "_rrdy"}, r_ready, 0);
    check({tag, "_awv"}, aw_valid, 0);
    check({tag, "_wv"}, w_valid, 0);
    check({tag, "_brdy"}, b_ready, 0);
    check({tag, "_rspv"}, rsp_valid, 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    all_quiet("rst");
    check("rst_err", rsp_err, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_araddr", ar_address, 0);
    check("rst_awaddr", aw_address, 0);
    check("rst_wdata", w_data, 0);
    rst_n = 1;
    tick();
    check("rst_cmdrdy", cmd_ready, 1);
    check("rst_state", o_dbg_state, 0);

    // T1: zero-wait read
    ar_ready = 1; r_valid = 1; r_data = 32'hDEADBEEF; r_resp = 0;
    exp_q.push_back(32'hDEADBEEF);
    send_cmd(0, 16'h0010, '0);
    check("t1_arv", ar_valid, 1);
    check("t1_araddr", ar_address, 16'h0010);
    check("t1_cmdrdy", cmd_ready, 0);
    check("t1_rrdy_c1", r_ready, 0);
    tick();
    check("t1_rrdy", r_ready, 1);
    check("t1_arv_c2", ar_valid, 0);
    check("t1_rspv_c2", rsp_valid, 0);
    tick();
    check("t1_rspv", rsp_valid, 1);
    check("t1_rdata", rsp_rdata, exp_q.pop_front());
    check("t1_err", rsp_err, 0);
    check("t1_rrdy_c3", r_ready, 0);
    idle_inputs();
    rsp_ready = 1;
    tick();
    check("t1_done_rspv", rsp_valid, 0);
    check("t1_done_cmdrdy", cmd_ready, 1);
    rsp_ready = 0;

    // T3: zero-wait write with error response (rdata must clear to 0)
    aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 1;
    exp_q.push_back(32'h0);
    send_cmd(1, 16'h0044, 32'hA5A5A5A5);
    check("t3_awv", aw_valid, 1);
    check("t3_wv", w_valid, 1);
    check("t3_brdy_c1", b_ready, 0);
    tick();
    check("t3_brdy", b_ready, 1);
    check("t3_awv_c2", aw_valid, 0);
    check("t3_wv_c2", w_valid, 0);
    tick();
    check("t3_rspv", rsp_valid, 1);
    check("t3_err", rsp_err, 1);
    check("t3_rdata", rsp_rdata, exp_q.pop_front());
    idle_inputs();
    rsp_ready = 1;
    tick();
    check("t3_done_rspv", rsp_valid, 0);
    rsp_ready = 0;

    // T2: write, aw_ready delayed, w_ready immediate, early b_valid held
    w_ready = 1; b_valid = 1; b_resp = 0;
    send_cmd(1, 16'h0020, 32'h12345678);
    check("t2_awaddr", aw_address, 16'h0020);
    check("t2_wdata", w_data, 32'h12345678);
    check("t2_awv_c1", aw_valid, 1);
    check("t2_wv_c1", w_valid, 1);
    tick();
    check("t2_wv_c2", w_valid, 0);
    check("t2_awv_c2", aw_valid, 1);
    check("t2_brdy_c2", b_ready, 0);
    tick();
    check("t2_awv_c3", aw_valid, 1);
    check("t2_brdy_c3", b_ready, 0);
    check("t2_awaddr_c3", aw_address, 16'h0020);
    aw_ready = 1;
    tick();
    aw_ready = 0;
    check("t2_awv_c4", aw_valid, 0);
    check("t2_brdy_c4", b_ready, 1);
    check("t2_rspv_c4", rsp_valid, 0);
    tick();
    check("t2_rspv", rsp_valid, 1);
    check("t2_err", rsp_err, 0);
    check("t2_rdata", rsp_rdata, 0);
    check("t2_brdy_c5", b_ready, 0);
    idle_inputs();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("t2_done_cmdrdy", cmd_ready, 1);

    // T4: read with error, response back-pressured 5 cycles
    ar_ready = 1; r_valid = 1; r_data = 32'hCAFE0001; r_resp = 1;
    exp_q.push_back(32'hCAFE0001);
    send_cmd(0, 16'h0030, '0);
    tick();
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      check("t4_rspv_hold", rsp_valid, 1);
      check("t4_rdata_hold", rsp_rdata, exp_q[0]);
      check("t4_err_hold", rsp_err, 1);
      check("t4_cmdrdy_hold", cmd_ready, 0);
      tick();
    end
    void'(exp_q.pop_front());
    rsp_ready = 1;
    check("t4_rspv_last", rsp_valid, 1);
    tick();
    rsp_ready = 0;
    check("t4_done_rspv", rsp_valid, 0);
    check("t4_done_cmdrdy", cmd_ready, 1);
    check("t4_done_state", o_dbg_state, 0);

    // T5: reset while waiting in RD_D
    ar_ready = 1;
    send_cmd(0, 16'h0040, '0);
    tick();
    ar_ready = 0;
    check("t5_rrdy", r_ready, 1);
    rst_n = 0;
    tick();
    all_quiet("t5_rst");
    rst_n = 1;
    tick();
    check("t5_cmdrdy", cmd_ready, 1);
    r_valid = 1; r_data = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_rsp", rsp_valid, 0);
      check("t5_no_rrdy", r_ready, 0);
      tick();
    end
    idle_inputs();

`ifdef AXIL_MASTER_TIMEOUT_EN
    // T6: ar_ready stuck low -> watchdog abort after TO cycles
    begin
      int n_hi;
      n_hi = 0;
      send_cmd(0, 16'h0050, '0);
      for (int i = 0; i < 20 && ar_valid; i++) begin
        n_hi++;
        tick();
      end
      check("t6_arv_cycles", n_hi, TO);
      check("t6_arv", ar_valid, 0);
      check("t6_rspv", rsp_valid, 1);
      check("t6_err", rsp_err, 1);
      check("t6_rdata", rsp_rdata, 0);
      r_valid = 1;
      tick();
      check("t6_late_rrdy", r_ready, 0);
      rsp_ready = 1;
      tick();
      idle_inputs();
      check("t6_done_rspv", rsp_valid, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
